pn_token_feeder: RTL and testbench

- Upstream framing stage for the Polish Notation evaluator.
- Accepts expression tokens from the host over a valid/ready stream and buffers one frame, up to DEPTH tokens.
- Checks each frame for structural validity against its mode while the frame is loading.
- Replays a valid frame to the evaluator as one contiguous in_valid burst, then holds off the host until the evaluator has finished emitting its results.

---
 rtl/pn_token_feeder_if.sv | 22 ++
 rtl/pn_token_feeder.sv | 145 ++++++++++++++
 tb/tb_pn_token_feeder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pn_token_feeder_if.sv
// pn_token_feeder_if: host token stream and evaluator burst signals around the feeder
interface pn_token_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_operator;
  logic [2:0] s_val;
  logic [1:0] s_mode;
  logic       s_last;
  logic       m_in_valid;
  logic [1:0] m_mode;
  logic       m_operator;
  logic [2:0] m_in;
  logic       pn_out_valid;
  modport master (
    output s_valid, s_operator, s_val, s_mode, s_last, pn_out_valid,
    input  s_ready, m_in_valid, m_mode, m_operator, m_in
  );
  modport slave (
    input  s_valid, s_operator, s_val, s_mode, s_last, pn_out_valid,
    output s_ready, m_in_valid, m_mode, m_operator, m_in
  );
endinterface

// File: rtl/pn_token_feeder.sv
// pn_token_feeder: buffers and validates one PN frame, replays it as a burst, then waits for results
module pn_token_feeder #(
  parameter int DEPTH = 12,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pn_token_feeder_if.slave bus,
  output logic             frame_err,
  output logic             busy,
  output logic [7:0]       frame_cnt
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DROP = 3'd2, SEND = 3'd3, WAIT = 3'd4;
  logic [2:0] state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, rd_q, rd_d;
  logic [CNTW:0] lvl_q, lvl_d;
  logic [1:0] mode_q, mode_d, pos_q, pos_d;
  logic bad_q, bad_d, seen_q, seen_d, frame_err_q, frame_err_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic m_in_valid_q, m_in_valid_d, m_operator_q, m_operator_d;
  logic [1:0] m_mode_q, m_mode_d;
  logic [2:0] m_in_q, m_in_d;
  logic [3:0] mem_q [DEPTH];
  logic acc, first, op, tok_ok, end_ok, up, wr;
  logic [1:0] cm, p, p_n;
  logic [CNTW-1:0] idx, n;
  logic [CNTW:0] lv, lv_n;
  assign bus.s_ready = state_q == IDLE || state_q == LOAD || state_q == DROP;
  assign busy = state_q == SEND || state_q == WAIT;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign bus.m_in_valid = m_in_valid_q;
  assign bus.m_mode = m_mode_q;
  assign bus.m_operator = m_operator_q;
  assign bus.m_in = m_in_q;
  // lvl tracks stack depth in mode 3 and outstanding operands (need) in mode 2
  always_comb begin
    acc = bus.s_valid && bus.s_ready;
    first = state_q == IDLE;
    op = bus.s_operator;
    cm = first ? bus.s_mode : mode_q;
    idx = first ? '0 : cnt_q;
    p = first ? 2'd0 : pos_q;
    lv = first ? {{CNTW{1'b0}}, bus.s_mode == 2'd2} : lvl_q;
    n = idx + 1'b1;
    p_n = p == 2'd2 ? 2'd0 : p + 2'd1;
    up = cm[0] ? !op : op;
    lv_n = up ? lv + 1'b1 : lv - 1'b1;
    tok_ok = !cm[1] ? op == (p == (cm[0] ? 2'd2 : 2'd0)) :
             cm[0] ? !op || lv >= (CNTW+1)'(2) : op || lv != (CNTW+1)'(1) || bus.s_last;
    end_ok = tok_ok && !(!first && bad_q) && n >= CNTW'(3) &&
             (!cm[1] ? p == 2'd2 : lv_n == (cm[0] ? (CNTW+1)'(1) : (CNTW+1)'(0)));
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    lvl_d = lvl_q;
    mode_d = mode_q;
    pos_d = pos_q;
    bad_d = bad_q;
    seen_d = seen_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
    m_in_valid_d = 1'b0;
    m_mode_d = 2'd0;
    m_operator_d = 1'b0;
    m_in_d = 3'd0;
    wr = 1'b0;
    case (state_q)
      IDLE, LOAD: if (acc) begin
        if (!first && cnt_q == CNTW'(DEPTH)) begin
          state_d = bus.s_last ? IDLE : DROP;
          frame_err_d = bus.s_last;
        end else begin
          wr = 1'b1;
          cnt_d = n;
          mode_d = cm;
          pos_d = p_n;
          lvl_d = lv_n;
          bad_d = (!first && bad_q) || !tok_ok;
          rd_d = CNTW'(1);
          state_d = !bus.s_last ? LOAD : end_ok ? SEND : IDLE;
          frame_err_d = bus.s_last && !end_ok;
          m_in_valid_d = bus.s_last && end_ok;
          m_mode_d = m_in_valid_d ? cm : 2'd0;
          {m_operator_d, m_in_d} = m_in_valid_d ? mem_q[0] : 4'd0;
        end
      end
      DROP: if (acc && bus.s_last) begin
        state_d = IDLE;
        frame_err_d = 1'b1;
      end
      SEND: if (rd_q < cnt_q) begin
        m_in_valid_d = 1'b1;
        m_mode_d = mode_q;
        {m_operator_d, m_in_d} = mem_q[rd_q];
        rd_d = rd_q + 1'b1;
      end else begin
        state_d = WAIT;
        seen_d = 1'b0;
      end
      WAIT: begin
        seen_d = seen_q || bus.pn_out_valid;
        if (seen_q && !bus.pn_out_valid) begin
          state_d = IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      mode_q <= '0;
      pos_q <= '0;
      bad_q <= 1'b0;
      seen_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      m_in_valid_q <= 1'b0;
      m_mode_q <= '0;
      m_operator_q <= 1'b0;
      m_in_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      mode_q <= mode_d;
      pos_q <= pos_d;
      bad_q <= bad_d;
      seen_q <= seen_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      m_in_valid_q <= m_in_valid_d;
      m_mode_q <= m_mode_d;
      m_operator_q <= m_operator_d;
      m_in_q <= m_in_d;
      if (wr) mem_q[idx] <= {op, bus.s_val};
    end
endmodule

// File: tb/tb_pn_token_feeder.sv
// tb_pn_token_feeder: directed and random frames checked against a frame-level reference model
module tb_pn_token_feeder;
  localparam int DEPTH = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_err, busy;
  logic [7:0] frame_cnt;
  logic [7:0] exp_cnt = 8'd0;
  int checks = 0;
  int errors = 0;
  pn_token_feeder_if bus();
  pn_token_feeder #(.DEPTH(DEPTH), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // whole-frame verdict: size limits, then the structural rule of the mode
  function automatic bit model_ok(input logic [1:0] mode, input logic [3:0] t[$]);
    int d = mode == 2'd2 ? 1 : 0;
    int n = t.size();
    if (n < 3 || n > DEPTH) return 1'b0;
    for (int i = 0; i < n; i++) begin
      bit o = t[i][3];
      if (mode < 2'd2) begin
        if (o != (i % 3 == (mode == 2'd1 ? 2 : 0))) return 1'b0;
      end else if (mode == 2'd3) begin
        if (o && d < 2) return 1'b0;
        d += o ? -1 : 1;
      end else begin
        d += o ? 1 : -1;
        if (d == 0 && i < n - 1) return 1'b0;
      end
    end
    return mode < 2'd2 ? n % 3 == 0 : d == (mode == 2'd3 ? 1 : 0);
  endfunction
  task automatic gen(output logic [1:0] mode, output logic [3:0] t[$]);
    int opn, opr, d, k, x;
    mode = 2'($urandom_range(0, 3));
    t = {};
    if (mode < 2'd2) begin
      k = $urandom_range(1, 4);
      for (int g = 0; g < k; g++)
        for (int j = 0; j < 3; j++) t.push_back({j == (mode == 2'd1 ? 2 : 0), 3'($urandom)});
    end else begin
      opn = $urandom_range(2, 6);
      opr = opn - 1;
      d = 0;
      while (opn > 0 || opr > 0) begin
        logic [3:0] tok;
        if (opr > 0 && d >= 2 && (opn == 0 || $urandom_range(0, 1) == 1)) begin
          tok = {1'b1, 3'($urandom_range(0, 3))};
          opr--;
          d--;
        end else begin
          tok = {1'b0, 3'($urandom)};
          opn--;
          d++;
        end
        if (mode == 2'd2) t.push_front(tok);
        else t.push_back(tok);
      end
    end
    x = $urandom_range(0, 5);
    if (x == 0) begin
      k = $urandom_range(0, t.size() - 1);
      t[k][3] = ~t[k][3];
    end else if (x == 1) t.push_back({1'($urandom), 3'($urandom)});
    else if (x == 2 && t.size() > 1) void'(t.pop_back());
  endtask
  task automatic play(input logic [1:0] mode, input logic [3:0] t[$]);
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      chk("s_ready_load", bus.s_ready, 1);
      bus.s_valid = 1'b1;
      bus.s_operator = t[i][3];
      bus.s_val = t[i][2:0];
      bus.s_mode = i == 0 ? mode : 2'($urandom);
      bus.s_last = i == t.size() - 1;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.s_operator = 1'b0;
    bus.s_val = 3'd0;
  endtask
  task automatic frame(input logic [1:0] mode, input logic [3:0] t[$]);
    bit ok;
    int n;
    ok = model_ok(mode, t);
    n = t.size();
    play(mode, t);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        chk("beat_valid", bus.m_in_valid, 1);
        chk("beat_op", bus.m_operator, t[i][3]);
        chk("beat_in", bus.m_in, t[i][2:0]);
        chk("beat_mode", bus.m_mode, mode);
        chk("busy_send", busy, 1);
      end
      @(negedge clk);
      chk("burst_end", {bus.m_in_valid, bus.m_operator, bus.m_in, bus.m_mode}, 0);
      chk("wait_ready", bus.s_ready, 0);
      chk("busy_wait", busy, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.pn_out_valid = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      chk("wait_hold", bus.s_ready, 0);
      bus.pn_out_valid = 1'b0;
      @(negedge clk);
      exp_cnt++;
      chk("done_ready", bus.s_ready, 1);
      chk("frame_cnt", frame_cnt, exp_cnt);
      chk("busy_idle", busy, 0);
    end else begin
      chk("err_pulse", frame_err, 1);
      chk("err_no_burst", bus.m_in_valid, 0);
      @(negedge clk);
      chk("err_clear", frame_err, 0);
      chk("err_no_burst2", bus.m_in_valid, 0);
      chk("err_cnt", frame_cnt, exp_cnt);
      chk("err_ready", bus.s_ready, 1);
    end
  endtask
  initial begin
    logic [3:0] t[$];
    logic [1:0] m;
    bus.s_valid = 1'b0;
    bus.s_operator = 1'b0;
    bus.s_val = 3'd0;
    bus.s_mode = 2'd0;
    bus.s_last = 1'b0;
    bus.pn_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.s_ready, 1);
    chk("rst_valid", bus.m_in_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    t = '{4'h3, 4'h2, 4'hA, 4'h1, 4'h8};
    frame(2'd3, t);
    t = '{4'h8, 4'h3, 4'hA, 4'h2, 4'h1};
    frame(2'd2, t);
    t = '{4'hA, 4'h3, 4'h4, 4'h8, 4'h1, 4'h5};
    frame(2'd0, t);
    t = '{4'hA, 4'hB, 4'h4, 4'h8, 4'h1, 4'h5};
    frame(2'd0, t);
    t = '{4'h1, 4'h8, 4'h2};
    frame(2'd3, t);
    t = '{4'h3, 4'h2, 4'hA, 4'h1, 4'h8};
    frame(2'd3, t);
    t = {};
    for (int i = 0; i < 14; i++) t.push_back({i % 3 == 2, 3'(i)});
    frame(2'd1, t);
    @(negedge clk);
    bus.pn_out_valid = 1'b1;
    @(negedge clk);
    bus.pn_out_valid = 1'b0;
    @(negedge clk);
    chk("idle_pn_cnt", frame_cnt, exp_cnt);
    chk("idle_pn_ready", bus.s_ready, 1);
    for (int r = 0; r < 40; r++) begin
      gen(m, t);
      frame(m, t);
    end
    t = '{4'h3, 4'h2, 4'hA, 4'h1, 4'h8};
    play(2'd3, t);
    chk("pre_rst_beat1", bus.m_in_valid, 1);
    repeat (2) @(negedge clk);
    chk("pre_rst_beat3", bus.m_in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.m_in_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", bus.s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    @(negedge clk);
    chk("post_rst_ready", bus.s_ready, 1);
    chk("post_rst_cnt", frame_cnt, 0);
    chk("post_rst_valid", bus.m_in_valid, 0);
    t = '{4'h8, 4'h3, 4'hA, 4'h2, 4'h1};
    frame(2'd2, t);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
